spu_local_store: RTL and testbench

Parametrised quadword load/store unit for the SPU odd pipe. It replaces the fixed 32 KB, fixed-latency, x-form-only store. It supports d-form, x-form and a-form quadword loads and stores. Local-store size and writeback latency are parameters, and address wrap follows the local-store limit mask. It adds a power-on clear sequencer and a writeback flush for branch-mispredict recovery. The unit sits between RF/FWD issue and the writeback stage; its outputs feed the register-table write port.

---
 rtl/spu_ls_pkg.sv | 45 ++++
 rtl/spu_ls_delay_pipe.sv | 42 ++++
 rtl/spu_local_store.sv | 119 +++++++++++
 tb/tb_spu_local_store.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/spu_ls_pkg.sv
// Shared types and address helpers for the SPU quadword local store.
package spu_ls_pkg;

    typedef enum logic [2:0] {
        LS_NOP = 3'd0,
        LQD    = 3'd1,
        LQX    = 3'd2,
        LQA    = 3'd3,
        STQD   = 3'd4,
        STQX   = 3'd5,
        STQA   = 3'd6
    } ls_op_t;

    localparam int QW_BYTES = 16;
    localparam int QW_BITS  = 128;

    typedef struct packed {
        logic [QW_BITS-1:0] rt;
        logic [6:0]         rt_addr;
        logic               reg_write;
    } ls_stage_t;

    // Unmasked 32-bit effective address; ra/rb are the preferred-slot words.
    function automatic logic [31:0] ls_ea(ls_op_t op, logic [31:0] ra, logic [31:0] rb,
                                          logic [15:0] imm);
        logic [31:0] ea;
        ea = '0;
        case (op)
            LQD, STQD: ea = ra + {{18{imm[9]}}, imm[9:0], 4'b0000};
            LQX, STQX: ea = ra + rb;
            LQA, STQA: ea = {{14{imm[15]}}, imm, 2'b00};
            default:   ea = '0;
        endcase
        return ea;
    endfunction

    function automatic logic ls_is_load(ls_op_t op);
        return (op == LQD) || (op == LQX) || (op == LQA);
    endfunction

    function automatic logic ls_is_store(ls_op_t op);
        return (op == STQD) || (op == STQX) || (op == STQA);
    endfunction

endpackage

// File: rtl/spu_ls_delay_pipe.sv
// Fixed-depth {rt, rt_addr, reg_write} shift register between issue and writeback.
module spu_ls_delay_pipe
    import spu_ls_pkg::*;
#(
    parameter int DEPTH = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic [QW_BITS-1:0]  rt,
    input  logic [6:0]          rt_addr,
    input  logic                reg_write,
    output logic [QW_BITS-1:0]  rt_wb,
    output logic [6:0]          rt_addr_wb,
    output logic                reg_write_wb
);

    ls_stage_t stages [DEPTH];

    // Flush kills everything already in flight; the op entering this edge survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                stages[k] <= '0;
            end
        end else begin
            stages[0].rt        <= rt;
            stages[0].rt_addr   <= rt_addr;
            stages[0].reg_write <= reg_write;
            for (int k = 1; k < DEPTH; k++) begin
                stages[k].rt        <= stages[k-1].rt;
                stages[k].rt_addr   <= stages[k-1].rt_addr;
                stages[k].reg_write <= stages[k-1].reg_write & ~flush;
            end
        end
    end

    assign rt_wb        = stages[DEPTH-1].rt;
    assign rt_addr_wb   = stages[DEPTH-1].rt_addr;
    assign reg_write_wb = stages[DEPTH-1].reg_write;

endmodule

// File: rtl/spu_local_store.sv
// Parametrised SPU local store: d/x/a-form quadword loads and stores with power-on clear.
module spu_local_store
    import spu_ls_pkg::*;
#(
    parameter int LS_BYTES       = 32768,
    parameter int LATENCY        = 6,
    parameter int CLR_QW_PER_CYC = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid_in,
    input  ls_op_t        op,
    input  logic [6:0]    rt_addr,
    input  logic [127:0]  ra,
    input  logic [127:0]  rb,
    input  logic [127:0]  rt_st,
    input  logic [15:0]   imm,
    input  logic          flush,
    output logic          busy,
    output logic [127:0]  rt_wb,
    output logic [6:0]    rt_addr_wb,
    output logic          reg_write_wb
);

    localparam int QW_COUNT = LS_BYTES / QW_BYTES;
    localparam int IDX_W    = $clog2(QW_COUNT);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } ls_state_t;

    ls_state_t         state;
    ls_state_t         state_next;
    logic [IDX_W-1:0]  clr_ptr;
    logic              clr_last;

    logic [31:0]       ea;
    logic [IDX_W-1:0]  qw_idx;
    logic              issue;
    logic              do_load;
    logic              do_store;
    logic [127:0]      load_rt;
    logic [6:0]        load_rt_addr;
    logic              unused_bits;

    logic [0:QW_BITS-1] mem [QW_COUNT];

    assign clr_last = (clr_ptr == IDX_W'(QW_COUNT - CLR_QW_PER_CYC));
    assign busy     = (state == INIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= INIT;
            clr_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == INIT) begin
                clr_ptr <= clr_ptr + IDX_W'(CLR_QW_PER_CYC);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (clr_last) state_next = READY;
            READY:   state_next = READY;
            default: state_next = INIT;
        endcase
    end

    // Preferred slot is the most significant word; masking to the store size
    // and quadword alignment reduces to slicing the index out of the EA.
    assign ea     = ls_ea(op, ra[127:96], rb[127:96], imm);
    assign qw_idx = ea[IDX_W+3:4];

    assign issue    = valid_in & ~busy & ~reset & (op != LS_NOP);
    assign do_load  = issue & ls_is_load(op);
    assign do_store = issue & ls_is_store(op);

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            for (int k = 0; k < CLR_QW_PER_CYC; k++) begin
                mem[clr_ptr + IDX_W'(k)] <= '0;
            end
        end else if (do_store) begin
            mem[qw_idx] <= rt_st;
        end
    end

    // Stage 0 of the pipe doubles as the read register, so a load captures
    // the array contents at its issue edge.
    always_comb begin
        load_rt      = '0;
        load_rt_addr = '0;
        if (do_load) begin
            load_rt      = mem[qw_idx];
            load_rt_addr = rt_addr;
        end
    end

    spu_ls_delay_pipe #(
        .DEPTH (LATENCY)
    ) u_delay_pipe (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .rt           (load_rt),
        .rt_addr      (load_rt_addr),
        .reg_write    (do_load),
        .rt_wb        (rt_wb),
        .rt_addr_wb   (rt_addr_wb),
        .reg_write_wb (reg_write_wb)
    );

    assign unused_bits = ^{ra[95:0], rb[95:0], ea[31:IDX_W+4], ea[3:0]};

endmodule

// File: tb/tb_spu_local_store.sv
// Scoreboard bench for spu_local_store: directed load/store, flush and init sequences.
module tb_spu_local_store;
    import spu_ls_pkg::*;

    localparam int LATENCY     = 6;
    localparam int INIT_CYCLES = 2048;

    localparam logic [127:0] DATA_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] DATA_B = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    localparam logic [127:0] DATA_C = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;
    localparam logic [127:0] DATA_D = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] DATA_E = 128'h11111111_22222222_33333333_44444444;

    logic          clk;
    logic          reset;
    logic          valid_in;
    ls_op_t        op;
    logic [6:0]    rt_addr;
    logic [127:0]  ra;
    logic [127:0]  rb;
    logic [127:0]  rt_st;
    logic [15:0]   imm;
    logic          flush;
    logic          busy;
    logic [127:0]  rt_wb;
    logic [6:0]    rt_addr_wb;
    logic          reg_write_wb;

    typedef struct {
        logic [127:0] rt;
        logic [6:0]   addr;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cycle = 0;
    int   check_count = 0;
    int   pass_count = 0;
    int   wb_count = 0;

    spu_local_store #(
        .LS_BYTES       (32768),
        .LATENCY        (LATENCY),
        .CLR_QW_PER_CYC (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .op           (op),
        .rt_addr      (rt_addr),
        .ra           (ra),
        .rb           (rb),
        .rt_st        (rt_st),
        .imm          (imm),
        .flush        (flush),
        .busy         (busy),
        .rt_wb        (rt_wb),
        .rt_addr_wb   (rt_addr_wb),
        .reg_write_wb (reg_write_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    endtask

    // Drives one op for one cycle; called right after a rising edge.
    task automatic applyStimulus(input ls_op_t o, input logic [31:0] ra_s,
                                 input logic [31:0] rb_s, input logic [15:0] im,
                                 input logic [127:0] st, input logic [6:0] rt,
                                 input logic fl, input bit exp_wb,
                                 input logic [127:0] exp_rt);
        valid_in = 1'b1;
        op       = o;
        ra       = {ra_s, 96'h0123_4567_89AB_CDEF_FEDC_BA98};
        rb       = {rb_s, 96'h7654_3210_0F1E_2D3C_4B5A_6978};
        imm      = im;
        rt_st    = st;
        rt_addr  = rt;
        flush    = fl;
        if (exp_wb) sb.push_back('{rt: exp_rt, addr: rt, cyc: cycle + LATENCY});
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        op       = LS_NOP;
        flush    = 1'b0;
    endtask

    task automatic drainScoreboard(input string name);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        checkOutput(name, sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every writeback must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reg_write_wb === 1'b1) begin
            wb_count++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_wb", reg_write_wb, 0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("wb_rt", rt_wb, mon_e.rt);
                checkOutput("wb_rt_addr", rt_addr_wb, mon_e.addr);
                checkOutput("wb_cycle", cycle, mon_e.cyc);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int wb_base;

        reset    = 1'b1;
        valid_in = 1'b0;
        op       = LS_NOP;
        rt_addr  = '0;
        ra       = '0;
        rb       = '0;
        rt_st    = '0;
        imm      = '0;
        flush    = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", busy, 1);
        checkOutput("reset_reg_write_wb", reg_write_wb, 0);
        checkOutput("reset_rt_wb", rt_wb, 0);
        checkOutput("reset_rt_addr_wb", rt_addr_wb, 0);

        @(posedge clk);
        #1;
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            n++;
        end
        checkOutput("init_busy_cycles", n, INIT_CYCLES);

        @(posedge clk);
        #1;
        applyStimulus(LQA,  32'h0, 32'h0, 16'h0000, '0, 7'd3, 1'b0, 1, '0);
        applyStimulus(STQX, 32'h100, 32'h20, 16'h0, DATA_A, 7'd0, 1'b0, 0, '0);
        applyStimulus(LQX,  32'h120, 32'h0F, 16'h0, '0, 7'd5, 1'b0, 1, DATA_A);
        applyStimulus(STQD, 32'h0, 32'h0, 16'h03FF, DATA_B, 7'd0, 1'b0, 0, '0);
        applyStimulus(LQA,  32'h0, 32'h0, 16'h1FFC, '0, 7'd7, 1'b0, 1, DATA_B);
        applyStimulus(LQD,  32'h8000, 32'h0, 16'hA7FF, '0, 7'd9, 1'b0, 1, DATA_B);
        applyStimulus(STQA, 32'h0, 32'h0, 16'h0040, DATA_C, 7'd0, 1'b0, 0, '0);
        applyStimulus(LQD,  32'h0F0, 32'h0, 16'h0001, '0, 7'd10, 1'b0, 1, DATA_C);
        drainScoreboard("drain_basic");

        repeat (LATENCY) @(posedge clk);
        #1;
        applyStimulus(LQA, 32'h0, 32'h0, 16'h0048, '0, 7'd11, 1'b0, 0, '0);
        applyStimulus(LQA, 32'h0, 32'h0, 16'h0048, '0, 7'd11, 1'b0, 0, '0);
        applyStimulus(LQA, 32'h0, 32'h0, 16'h0048, '0, 7'd12, 1'b1, 1, DATA_A);
        drainScoreboard("drain_flush1");

        repeat (LATENCY) @(posedge clk);
        #1;
        applyStimulus(LQA,  32'h0, 32'h0, 16'h0048, '0, 7'd13, 1'b0, 0, '0);
        applyStimulus(STQA, 32'h0, 32'h0, 16'h0080, DATA_D, 7'd0, 1'b0, 0, '0);
        applyStimulus(LQA,  32'h0, 32'h0, 16'h0080, '0, 7'd14, 1'b1, 1, DATA_D);
        applyStimulus(LQX,  32'h1F0, 32'h10, 16'h0, '0, 7'd15, 1'b0, 1, DATA_D);
        drainScoreboard("drain_flush2");

        repeat (LATENCY) @(posedge clk);
        #1;
        wb_base = wb_count;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(LQA, 32'h0, 32'h0, 16'h0048, '0, 7'(16 + i), 1'b0, 0, '0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("busy_reasserted", busy, 1);
        @(posedge clk);
        #1;
        applyStimulus(STQA, 32'h0, 32'h0, 16'h0048, DATA_E, 7'd0, 1'b0, 0, '0);
        applyStimulus(LQA,  32'h0, 32'h0, 16'h0048, '0, 7'd21, 1'b0, 0, '0);
        applyStimulus(LQX,  32'h120, 32'h0, 16'h0, '0, 7'd22, 1'b0, 0, '0);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
        end
        checkOutput("init2_done", busy, 0);
        checkOutput("no_wb_after_reset", wb_count - wb_base, 0);

        @(posedge clk);
        #1;
        applyStimulus(LQA, 32'h0, 32'h0, 16'h0048, '0, 7'd23, 1'b0, 1, '0);
        applyStimulus(LQA, 32'h0, 32'h0, 16'h0080, '0, 7'd24, 1'b0, 1, '0);
        applyStimulus(LQA, 32'h0, 32'h0, 16'h1FFC, '0, 7'd25, 1'b0, 1, '0);
        drainScoreboard("drain_final");

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
